register_read_port: RTL
=======================

// Module: register_read_port
// PURPOSE
//  Read side of the switchable register bank: fetches two register values (A and B operands) per request.
//  - Selects from the concatenated Q outputs of NUM_REGS switchable registers.
//  - Forwards a same-cycle S-bus store to the reader (bypass).
//  - Holds the result in a one-entry output buffer under a valid/ready handshake toward the ALU stage.
// PARAMETERS
//  WIDTH     16  data width of each register and of the A/B buses
//  NUM_REGS  8   number of registers in the bank
//  ADDR_W    3   register index width; must satisfy 2**ADDR_W >= NUM_REGS
//  BYPASS    1   1: a store to the addressed register in the accept cycle returns the new S_bus value; 0: returns the old Q value
// PORTS
//  CLK        in   1                clock, rising edge
//  CLR        in   1                asynchronous reset, active low
//  R_ALL      in   NUM_REGS*WIDTH   register Q outputs; register i occupies bits [i*WIDTH +: WIDTH]
//  SR_VEC     in   NUM_REGS         store strobes; bit i is the SR input of register i
//  S_bus      in   WIDTH            S bus (store data)
//  req_valid  in   1                read request valid
//  req_ready  out  1                read request can be accepted
//  addr_a     in   ADDR_W           register index for the A operand
//  addr_b     in   ADDR_W           register index for the B operand
//  rsp_valid  out  1                A_bus/B_bus hold a valid result
//  rsp_ready  in   1                consumer takes the result
//  A_bus      out  WIDTH            A operand
//  B_bus      out  WIDTH            B operand
//  rsp_err    out  1                an address in the held result was >= NUM_REGS
//  rsp_stale  out  1                a held source register was overwritten after capture
// BEHAVIOUR
//  - Reset (CLR=0, asynchronous): state=EMPTY; A_bus=0, B_bus=0, rsp_valid=0, rsp_err=0, rsp_stale=0.
//  - FSM states:
//    - EMPTY -> FULL on accept.
//    - FULL -> EMPTY on rsp_ready with no accept.
//    - FULL -> FULL on accept together with rsp_ready.
//  - Handshake signals:
//    - rsp_valid = (state==FULL).
//    - req_ready = (state==EMPTY) | rsp_ready.
//    - accept = req_valid & req_ready.
//  - Latency: a request accepted at edge N presents its data at edge N, with rsp_valid high in cycle N+1. Capture is registered, never combinational.
//  - Capture value per operand, x = addr_a or addr_b:
//    - x >= NUM_REGS: data = 0 and rsp_err is set.
//    - BYPASS=1 and SR_VEC[x]=1: data = S_bus.
//    - Otherwise: data = R_ALL[x*WIDTH +: WIDTH].
//  - addr_a == addr_b is legal; both buses return the same value.
//  - Hold: while FULL and rsp_ready=0, A_bus, B_bus, rsp_err and the held addresses stay constant. The buffer is a snapshot and never tracks later register changes.
//  - Staleness:
//    - While FULL, SR_VEC[held_a] or SR_VEC[held_b] asserted at an edge (with no accept at that edge) sets rsp_stale=1.
//    - rsp_stale is cleared on a new accept or on drain to EMPTY.
//    - With BYPASS=0, a store to a source register in the accept cycle sets rsp_stale=1 at capture.
//  - Simultaneous drain and accept: the new result replaces the old one at the same edge; there is no bubble.
//  - Outputs in EMPTY: A_bus and B_bus keep their last values; rsp_err=0, rsp_stale=0.
//  - Reset mid-transfer: the held data is discarded; no response is replayed.
// STRUCTURE
//  - Shared package reg_bank_pkg holds:
//    - WIDTH and NUM_REGS defaults.
//    - The rd_state_t enum {EMPTY, FULL}.
//    - The index-slice helper used by both reader and writer blocks.
//  - Sub-module reg_read_mux (combinational, one operand):
//    - Inputs: R_ALL, SR_VEC, S_bus, addr.
//    - Outputs: data, err, bypass_hit.
//    - Instantiated twice, for A and B.
//  - The top level holds the FSM, the output registers, the held addresses and the stale logic.
// TESTING
//  1. Reset: hold CLR=0 with random inputs -> A_bus=0, B_bus=0, rsp_valid=0, req_ready=1. Release CLR -> state stays EMPTY.
//  2. Basic read: R2=16'h1234, R5=16'hBEEF; req addr_a=2, addr_b=5 with rsp_ready=1 -> next cycle A_bus=16'h1234, B_bus=16'hBEEF, rsp_valid=1, rsp_err=0.
//  3. Bypass: R3=16'h0001, SR_VEC[3]=1, S_bus=16'hCAFE in the accept cycle, addr_a=3 -> A_bus=16'hCAFE. With BYPASS=0 -> A_bus=16'h0001 and rsp_stale=1.
//  4. Backpressure and stale:
//     - Capture addr_b=4 (R4=16'h0044), hold rsp_ready=0 for 3 cycles, store 16'h9999 to R4 in cycle 2.
//     - Required: B_bus stays 16'h0044, rsp_stale rises at that edge, req_ready=0 throughout.
//  5. Back-to-back: a new request every cycle with rsp_ready=1 (addresses 0..7 cycling) -> one result per cycle, in order, no gaps. addr_a=7, addr_b=7 -> both buses equal R7.
//  6. Error and reset:
//     - NUM_REGS=6, addr_a=6 -> A_bus=0, rsp_err=1.
//     - Assert CLR while FULL -> rsp_valid drops immediately, asynchronously, and both buses read 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the switchable register bank: default sizes,
// the read-port state type and the register slice helper.
package reg_bank_pkg;

  localparam int WIDTH_DEF    = 16;
  localparam int NUM_REGS_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rd_state_t;

  // Bit offset of register idx inside the concatenated Q bus.
  function automatic int reg_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_read_mux.sv
// One-operand register selector with same-cycle store bypass and
// out-of-range detection. Purely combinational.
module reg_read_mux
  import reg_bank_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1
) (
  input  logic [NUM_REGS*WIDTH-1:0] R_ALL,
  input  logic [NUM_REGS-1:0]       SR_VEC,
  input  logic [WIDTH-1:0]          S_bus,
  input  logic [ADDR_W-1:0]         addr,
  output logic [WIDTH-1:0]          data,
  output logic                      err,
  output logic                      bypass_hit
);

  localparam bit USE_BYPASS = (BYPASS != 0);

  // A decode loop keeps every slice in range even when addr >= NUM_REGS.
  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    data       = '0;
    err        = 1'b1;
    bypass_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) begin
        err        = 1'b0;
        bypass_hit = SR_VEC[i];
        data       = (USE_BYPASS && SR_VEC[i]) ? S_bus
                                               : R_ALL[reg_lsb(i, WIDTH) +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/register_read_port.sv
// Read port of the switchable register bank: captures A/B operands into a
// one-entry buffer and hands them to the ALU stage under valid/ready.
module register_read_port
  import reg_bank_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1
) (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic [NUM_REGS*WIDTH-1:0] R_ALL,
  input  logic [NUM_REGS-1:0]       SR_VEC,
  input  logic [WIDTH-1:0]          S_bus,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         addr_a,
  input  logic [ADDR_W-1:0]         addr_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WIDTH-1:0]          A_bus,
  output logic [WIDTH-1:0]          B_bus,
  output logic                      rsp_err,
  output logic                      rsp_stale
);

  localparam bit USE_BYPASS = (BYPASS != 0);

  rd_state_t         state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              err_q, err_d, stale_q, stale_d;
  logic [ADDR_W-1:0] held_a_q, held_a_d, held_b_q, held_b_d;

  logic [WIDTH-1:0]  data_a, data_b;
  logic              err_a, err_b, hit_a, hit_b;
  logic              accept, hold_hit;

  reg_read_mux #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .BYPASS(BYPASS))
    u_mux_a (.R_ALL(R_ALL), .SR_VEC(SR_VEC), .S_bus(S_bus), .addr(addr_a),
             .data(data_a), .err(err_a), .bypass_hit(hit_a));

  reg_read_mux #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .BYPASS(BYPASS))
    u_mux_b (.R_ALL(R_ALL), .SR_VEC(SR_VEC), .S_bus(S_bus), .addr(addr_b),
             .data(data_b), .err(err_b), .bypass_hit(hit_b));

  assign rsp_valid = (state_q == FULL);
  assign req_ready = (state_q == EMPTY) | rsp_ready;
  assign accept    = req_valid & req_ready;

  assign A_bus     = a_q;
  assign B_bus     = b_q;
  assign rsp_err   = err_q;
  assign rsp_stale = stale_q;

  // A store hitting either held source register makes the snapshot stale.
  always_comb begin
    hold_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (SR_VEC[i] && (held_a_q == ADDR_W'(i) || held_b_q == ADDR_W'(i))) begin
        hold_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    err_d    = err_q;
    stale_d  = stale_q;
    held_a_d = held_a_q;
    held_b_d = held_b_q;

    if (accept) begin
      state_d  = FULL;
      a_d      = data_a;
      b_d      = data_b;
      err_d    = err_a | err_b;
      stale_d  = !USE_BYPASS && (hit_a || hit_b);
      held_a_d = addr_a;
      held_b_d = addr_b;
    end else if (state_q == FULL) begin
      if (rsp_ready) begin
        state_d = EMPTY;
        err_d   = 1'b0;
        stale_d = 1'b0;
      end else begin
        stale_d = stale_q | hold_hit;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all logic is in the _d terms.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= EMPTY;
      a_q      <= '0;
      b_q      <= '0;
      err_q    <= 1'b0;
      stale_q  <= 1'b0;
      held_a_q <= '0;
      held_b_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      err_q    <= err_d;
      stale_q  <= stale_d;
      held_a_q <= held_a_d;
      held_b_q <= held_b_d;
    end
  end

endmodule
